// File: rtl/ppu_pkg.sv
// Shared constants and types for the PPU CPU register port.
package ppu_pkg;

    localparam int          VADDR_W    = 14;
    localparam logic [13:0] PAL_BASE   = 14'h3F00;
    // Palette reads refill the buffer from the nametable byte underneath them.
    localparam logic [13:0] MIRROR_OFS = 14'h1000;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_ADDR   = 3'd6;
    localparam logic [2:0] REG_DATA   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREQ,
        ST_RREQ,
        ST_RCAP,
        ST_SREQ,
        ST_SCAP
    } port_state_e;

endpackage

// File: rtl/ppu_cpu_port_if.sv
// CPU register bus and VRAM request bus of the PPU port. The port is the
// slave; the CPU plus the memory/arbiter side together form the master.
interface ppu_cpu_port_if;

    logic       cpu_cs;
    logic       cpu_we;
    logic [2:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic [7:0] status_in;
    logic       cpu_ready;
    logic       cpu_rvalid;
    logic [7:0] cpu_rdata;

    logic        mem_req;
    logic        mem_gnt;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    modport master (
        output cpu_cs, cpu_we, cpu_addr, cpu_wdata, status_in, mem_gnt, mem_rdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata, mem_req, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  cpu_cs, cpu_we, cpu_addr, cpu_wdata, status_in, mem_gnt, mem_rdata,
        output cpu_ready, cpu_rvalid, cpu_rdata, mem_req, mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/ppu_vaddr_reg.sv
// VRAM address register v with the PPUADDR write toggle and the
// post-access increment, wrapping modulo 2^ADDR_W.
module ppu_vaddr_reg #(
    parameter int ADDR_W = ppu_pkg::VADDR_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              load_hi_i,
    input  logic              load_lo_i,
    input  logic              inc_i,
    input  logic              inc32_i,
    input  logic              clr_toggle_i,
    input  logic [7:0]        data_i,
    output logic [ADDR_W-1:0] v_o,
    output logic              toggle_o
);

    logic [ADDR_W-1:0] v_q, v_d;
    logic              w_q, w_d;
    logic [ADDR_W-1:0] step;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
        step = inc32_i ? ADDR_W'(32) : ADDR_W'(1);
        v_d  = v_q;
        w_d  = w_q;
        if (load_hi_i) begin
            v_d[ADDR_W-1:8] = data_i[ADDR_W-9:0];
            w_d             = 1'b1;
        end else if (load_lo_i) begin
            v_d[7:0] = data_i;
            w_d      = 1'b0;
        end else if (inc_i) begin
            v_d = v_q + step;
        end
        if (clr_toggle_i) begin
            w_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            v_q <= '0;
            w_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so the order of statements never changes what is sampled.
            v_q <= v_d;
            w_q <= w_d;
        end
    end

    assign v_o      = v_q;
    assign toggle_o = w_q;

endmodule

// File: rtl/ppu_cpu_port.sv
// CPU register port of the PPU: decodes $2000/$2002/$2006/$2007, sequences
// VRAM accesses through the renderer arbiter and keeps the PPUDATA read buffer.
module ppu_cpu_port #(
    parameter int                ADDR_W   = ppu_pkg::VADDR_W,
    parameter logic [ADDR_W-1:0] PAL_BASE = ADDR_W'(ppu_pkg::PAL_BASE)
) (
    input logic           CLK,
    input logic           RESET_N,
    ppu_cpu_port_if.slave bus
);
    import ppu_pkg::*;

    port_state_e       state_q;
    logic              ready_q;
    logic              rvalid_q;
    logic              req_q;
    logic              inc32_q;
    logic [7:0]        rdata_q;
    logic [7:0]        wdata_q;
    logic [7:0]        rbuf_q;

    logic              accept;
    logic              load_hi, load_lo, inc_v, clr_toggle;
    logic              toggle;
    logic [ADDR_W-1:0] v;
    logic [ADDR_W-1:0] mem_vaddr;
    logic              is_pal;

    // ready_q is only ever high in IDLE, so it doubles as the idle qualifier.
    assign accept = bus.cpu_cs && ready_q;
    assign is_pal = (v >= PAL_BASE);

    always_comb begin
        load_hi    = 1'b0;
        load_lo    = 1'b0;
        clr_toggle = 1'b0;
        if (accept && bus.cpu_we && bus.cpu_addr == REG_ADDR) begin
            load_hi = !toggle;
            load_lo = toggle;
        end
        if (accept && !bus.cpu_we && bus.cpu_addr == REG_STATUS) begin
            clr_toggle = 1'b1;
        end
        inc_v = (state_q == ST_WREQ && bus.mem_gnt)
             || (state_q == ST_RCAP && !is_pal)
             || (state_q == ST_SCAP);
    end

    ppu_vaddr_reg #(.ADDR_W(ADDR_W)) u_vaddr (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .load_hi_i    (load_hi),
        .load_lo_i    (load_lo),
        .inc_i        (inc_v),
        .inc32_i      (inc32_q),
        .clr_toggle_i (clr_toggle),
        .data_i       (bus.cpu_wdata),
        .v_o          (v),
        .toggle_o     (toggle)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            req_q    <= 1'b0;
            inc32_q  <= 1'b0;
            rdata_q  <= '0;
            wdata_q  <= '0;
            rbuf_q   <= '0;
        end else begin
            rvalid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept && bus.cpu_we) begin
                        case (bus.cpu_addr)
                            REG_CTRL: inc32_q <= bus.cpu_wdata[2];
                            REG_DATA: begin
                                wdata_q <= bus.cpu_wdata;
                                req_q   <= 1'b1;
                                ready_q <= 1'b0;
                                state_q <= ST_WREQ;
                            end
                            default: ;
                        endcase
                    end else if (accept) begin
                        case (bus.cpu_addr)
                            REG_STATUS: begin
                                rdata_q  <= bus.status_in;
                                rvalid_q <= 1'b1;
                            end
                            REG_DATA: begin
                                req_q   <= 1'b1;
                                ready_q <= 1'b0;
                                state_q <= ST_RREQ;
                            end
                            default: begin
                                rdata_q  <= '0;
                                rvalid_q <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_WREQ: begin
                    if (bus.mem_gnt) begin
                        req_q   <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RREQ: begin
                    if (bus.mem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= ST_RCAP;
                    end
                end
                ST_RCAP: begin
                    rvalid_q <= 1'b1;
                    if (is_pal) begin
                        // Palette data bypasses the buffer; the buffer is refilled from the mirror.
                        rdata_q <= bus.mem_rdata;
                        req_q   <= 1'b1;
                        state_q <= ST_SREQ;
                    end else begin
                        rdata_q <= rbuf_q;
                        rbuf_q  <= bus.mem_rdata;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SREQ: begin
                    if (bus.mem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= ST_SCAP;
                    end
                end
                ST_SCAP: begin
                    rbuf_q  <= bus.mem_rdata;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_vaddr = v;
        if (state_q == ST_SREQ || state_q == ST_SCAP) begin
            mem_vaddr = v - ADDR_W'(MIRROR_OFS);
        end
    end

    assign bus.cpu_ready  = ready_q;
    assign bus.cpu_rvalid = rvalid_q;
    assign bus.cpu_rdata  = rdata_q;
    assign bus.mem_req    = req_q;
    assign bus.mem_addr   = 16'(mem_vaddr);
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_we     = (state_q == ST_WREQ) && bus.mem_gnt;

endmodule

// File: tb/tb_ppu_cpu_port.sv
// Self-checking bench for ppu_cpu_port: a transaction-level model of the
// register semantics predicts every read result, VRAM write and v value.
module tb_ppu_cpu_port;

    localparam int BUDGET = 200;

    logic CLK = 1'b0;
    logic RESET_N;

    ppu_cpu_port_if bus ();

    ppu_cpu_port #(.ADDR_W(14), .PAL_BASE(14'h3F00)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Environment memory (what the DUT talks to) and model memory (what it should contain).
    logic [7:0] vram  [16384];
    logic [7:0] m_mem [16384];
    logic [7:0] pend;
    bit         pend_v = 1'b0;
    int         gnt_mode = 1;  // 0: grant low, 1: grant high, 2: random

    int         m_v;
    bit         m_w;
    bit         m_inc32;
    logic [7:0] m_rbuf;
    logic [7:0] exp_rd [$];
    logic [23:0] exp_wr [$];

    int          we_count = 0;
    logic [15:0] last_we_addr;
    logic [7:0]  last_we_data;
    logic [23:0] cmp_e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: wait bound of %0d cycles expired", name, BUDGET);
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    function automatic void model_reset();
        m_v = 0; m_w = 1'b0; m_inc32 = 1'b0; m_rbuf = 8'h00;
        exp_rd.delete();
        exp_wr.delete();
    endfunction

    // One CPU access, applied to the model in program order.
    function automatic void model_access(input bit we, input logic [2:0] a,
                                         input logic [7:0] d, input logic [7:0] st);
        int inc;
        inc = m_inc32 ? 32 : 1;
        case (a)
            3'd0: if (we) m_inc32 = d[2]; else exp_rd.push_back(8'h00);
            3'd2: if (!we) begin exp_rd.push_back(st); m_w = 1'b0; end
            3'd6: begin
                if (!we) exp_rd.push_back(8'h00);
                else if (!m_w) begin m_v = (m_v & 'hFF) | ((int'(d) & 'h3F) << 8); m_w = 1'b1; end
                else begin m_v = (m_v & 'h3F00) | int'(d); m_w = 1'b0; end
            end
            3'd7: begin
                if (we) begin
                    exp_wr.push_back({16'(m_v), d});
                    m_mem[m_v] = d;
                end else if (m_v < 'h3F00) begin
                    exp_rd.push_back(m_rbuf);
                    m_rbuf = m_mem[m_v];
                end else begin
                    exp_rd.push_back(m_mem[m_v]);
                    m_rbuf = m_mem[m_v - 'h1000];
                end
                m_v = (m_v + inc) % 16384;
            end
            default: if (!we) exp_rd.push_back(8'h00);
        endcase
    endfunction

    // Memory: capture on the grant cycle, present read data the following cycle.
    initial forever begin
        @(negedge CLK);
        if (RESET_N === 1'b1 && bus.mem_req && bus.mem_gnt) begin
            if (bus.mem_we) vram[bus.mem_addr[13:0]] = bus.mem_wdata;
            else begin pend = vram[bus.mem_addr[13:0]]; pend_v = 1'b1; end
        end
    end

    initial forever begin
        @(posedge CLK);
        #1;
        bus.mem_rdata = pend_v ? pend : 8'($urandom);
        pend_v = 1'b0;
        case (gnt_mode)
            0:       bus.mem_gnt = 1'b0;
            1:       bus.mem_gnt = 1'b1;
            default: bus.mem_gnt = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Compare process: every cycle, outputs against the model's expectations.
    initial forever begin
        @(negedge CLK);
        if (RESET_N === 1'b1) begin
            check("mem_addr_upper", 32'(bus.mem_addr[15:14]), 0);
            if (bus.cpu_ready) check("idle_no_req", 32'(bus.mem_req), 0);
            if (bus.cpu_rvalid) begin
                check("rd_expected", 32'(exp_rd.size() != 0), 1);
                if (exp_rd.size() != 0) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_rd.pop_front()));
            end
            if (bus.mem_we) begin
                we_count++;
                last_we_addr = bus.mem_addr;
                last_we_data = bus.mem_wdata;
                check("we_with_req_gnt", 32'({bus.mem_req, bus.mem_gnt}), 32'(2'b11));
                check("wr_expected", 32'(exp_wr.size() != 0), 1);
                if (exp_wr.size() != 0) begin
                    cmp_e = exp_wr.pop_front();
                    check("mem_addr_on_we", 32'(bus.mem_addr), 32'(cmp_e[23:8]));
                    check("mem_wdata_on_we", 32'(bus.mem_wdata), 32'(cmp_e[7:0]));
                end
            end
        end
    end

    task automatic access(input bit we, input logic [2:0] a, input logic [7:0] d,
                          input logic [7:0] st, output logic [7:0] rd);
        int n;
        bit got;
        rd = 8'h00;
        n  = 0;
        while (!bus.cpu_ready && n < BUDGET) begin tick(); n++; end
        if (!bus.cpu_ready) begin fail("ready_before_access"); return; end
        bus.status_in = st;
        model_access(we, a, d, st);
        bus.cpu_cs = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        tick();
        bus.cpu_cs = 1'b0;
        got = 1'b0;
        n   = 0;
        while (1) begin
            if (bus.cpu_rvalid) begin rd = bus.cpu_rdata; got = 1'b1; end
            if (bus.cpu_ready && (we || got)) break;
            if (n >= BUDGET) begin fail("access_complete"); return; end
            tick();
            n++;
        end
        check("v_after_access", 32'(bus.mem_addr), 32'(m_v));
    endtask

    task automatic set_v(input logic [15:0] addr);
        logic [7:0] rd;
        access(1'b1, 3'd6, addr[15:8], 8'h00, rd);
        access(1'b1, 3'd6, addr[7:0], 8'h00, rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic [7:0] b;
        int         wc0;
        int         r;
        logic [2:0] a;
        logic [7:0] d;

        RESET_N       = 1'b0;
        bus.cpu_cs    = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 3'd0;
        bus.cpu_wdata = 8'h00;
        bus.status_in = 8'h00;
        bus.mem_gnt   = 1'b0;
        bus.mem_rdata = 8'h00;
        for (int i = 0; i < 16384; i++) begin
            b = 8'($urandom);
            vram[i]  = b;
            m_mem[i] = b;
        end
        model_reset();

        #12;
        check("rst_cpu_ready", 32'(bus.cpu_ready), 1);
        check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
        check("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
        check("rst_mem_req", 32'(bus.mem_req), 0);
        check("rst_mem_we", 32'(bus.mem_we), 0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
        check("rst_v", 32'(bus.mem_addr), 0);
        #10;
        RESET_N = 1'b1;
        tick();

        // Address load then a data write with grant tied high.
        gnt_mode = 1;
        wc0 = we_count;
        access(1'b1, 3'd6, 8'h21, 8'h00, rd);
        access(1'b1, 3'd6, 8'h08, 8'h00, rd);
        access(1'b1, 3'd7, 8'h5A, 8'h00, rd);
        check("t1_we_pulses", 32'(we_count - wc0), 1);
        check("t1_we_addr", 32'(last_we_addr), 32'h2108);
        check("t1_we_data", 32'(last_we_data), 32'h5A);
        check("t1_v", 32'(bus.mem_addr), 32'h2109);

        // Buffered reads lag by one access.
        vram[14'h2000] = 8'h11; m_mem[14'h2000] = 8'h11;
        vram[14'h2001] = 8'h22; m_mem[14'h2001] = 8'h22;
        set_v(16'h2000);
        access(1'b0, 3'd7, 8'h00, 8'h00, rd); check("t2_read0", 32'(rd), 32'h00);
        access(1'b0, 3'd7, 8'h00, 8'h00, rd); check("t2_read1", 32'(rd), 32'h11);
        access(1'b0, 3'd7, 8'h00, 8'h00, rd); check("t2_read2", 32'(rd), 32'h22);

        // Palette read bypass with shadow refill from the nametable mirror.
        vram[14'h3F05] = 8'h2C; m_mem[14'h3F05] = 8'h2C;
        vram[14'h2F05] = 8'h77; m_mem[14'h2F05] = 8'h77;
        set_v(16'h3F05);
        access(1'b0, 3'd7, 8'h00, 8'h00, rd); check("t3_pal_read", 32'(rd), 32'h2C);
        check("t3_v", 32'(bus.mem_addr), 32'h3F06);
        set_v(16'h0000);
        access(1'b0, 3'd7, 8'h00, 8'h00, rd); check("t3_shadow_rbuf", 32'(rd), 32'h77);

        // Increment wrap in both step sizes.
        access(1'b1, 3'd0, 8'h04, 8'h00, rd);
        set_v(16'h3FF0);
        access(1'b1, 3'd7, 8'h99, 8'h00, rd);
        check("t4_we_addr32", 32'(last_we_addr), 32'h3FF0);
        check("t4_v_wrap32", 32'(bus.mem_addr), 32'h0010);
        access(1'b1, 3'd0, 8'h00, 8'h00, rd);
        set_v(16'h3FFF);
        access(1'b1, 3'd7, 8'h42, 8'h00, rd);
        check("t4_v_wrap1", 32'(bus.mem_addr), 32'h0000);

        // Status read clears the half-written address toggle.
        access(1'b1, 3'd6, 8'h12, 8'h00, rd);
        access(1'b0, 3'd2, 8'h00, 8'h80, rd); check("t5_status", 32'(rd), 32'h80);
        access(1'b1, 3'd6, 8'h23, 8'h00, rd);
        access(1'b1, 3'd6, 8'h45, 8'h00, rd);
        check("t5_v", 32'(bus.mem_addr), 32'h2345);

        // Grant withheld for ten cycles; a chip select while busy must be ignored.
        gnt_mode = 0;
        tick();
        model_access(1'b1, 3'd7, 8'h3C, 8'h00);
        bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 3'd7; bus.cpu_wdata = 8'h3C;
        tick();
        bus.cpu_cs = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t6_stall_ready", 32'(bus.cpu_ready), 0);
            check("t6_stall_we", 32'(bus.mem_we), 0);
            if (i == 3) begin
                bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 3'd6; bus.cpu_wdata = 8'hFF;
            end
            if (i == 4) bus.cpu_cs = 1'b0;
            tick();
        end
        gnt_mode = 1;
        tick();
        check("t6_gnt_we", 32'(bus.mem_we), 1);
        check("t6_gnt_busy", 32'(bus.cpu_ready), 0);
        tick();
        check("t6_done_ready", 32'(bus.cpu_ready), 1);
        check("t6_v", 32'(bus.mem_addr), 32'h2346);

        // Reset in the middle of a pending read.
        gnt_mode = 0;
        set_v(16'h1234);
        bus.cpu_cs = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 3'd7;
        tick();
        bus.cpu_cs = 1'b0;
        tick();
        tick();
        check("t7_req_pending", 32'(bus.mem_req), 1);
        #1;
        RESET_N = 1'b0;
        #1;
        check("t7_rst_req", 32'(bus.mem_req), 0);
        check("t7_rst_ready", 32'(bus.cpu_ready), 1);
        check("t7_rst_v", 32'(bus.mem_addr), 0);
        model_reset();
        tick();
        tick();
        RESET_N = 1'b1;
        tick();

        // Randomized traffic with random grant stalls.
        gnt_mode = 2;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 15);
            if (r < 2)       a = 3'd0;
            else if (r < 4)  a = 3'd2;
            else if (r < 8)  a = 3'd6;
            else if (r < 14) a = 3'd7;
            else             a = 3'($urandom_range(3, 5));
            if (r == 15 && a == 3'd3) a = 3'd1;
            d = 8'($urandom);
            if (a == 3'd6 && !m_w && $urandom_range(0, 2) == 0) d = d | 8'h3F;
            access(1'($urandom_range(0, 1)), a, d, 8'($urandom), rd);
        end
        tick();
        tick();
        check("rd_queue_drained", 32'(exp_rd.size()), 0);
        check("wr_queue_drained", 32'(exp_wr.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
